// File: rtl/slave_pkg.sv
// slave_pkg: definitions shared by the SPI slave and the spi_ram block
// behind it.
//   ram_cmd_e : 2-bit command prefix carried in the top bits of each
//               10-bit parallel word handed from the slave to the RAM.
package slave_pkg;

  typedef enum logic [1:0] {
    WRITE_ADD  = 2'b00,
    WRITE_DATA = 2'b01,
    READ_ADD   = 2'b10,
    READ_DATA  = 2'b11
  } ram_cmd_e;

endpackage

// File: rtl/spi_ram.sv
// spi_ram: single-port synchronous RAM behind the SPI slave.
// It decodes the 2-bit command prefix of each received word into
// write-address, write-data, read-address and read-data operations.
// Data commands that arrive before a matching address command are
// rejected, and so are address commands that fall outside the array.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : synchronous active-low reset; memory contents are kept
//   rx_data  : {cmd[1:0], payload[ADDR_SIZE-1:0]} from the slave
//   rx_valid : word valid from the slave; a command runs on its rising edge
//   tx_data  : read data back to the slave
//   tx_valid : tx_data valid, held until the next executed command
//   cmd_err  : one-cycle pulse for each rejected command
//
// Build option
//   SPI_RAM_AUTO_INC_EN : when defined, successful data commands advance
//                         their address register, wrapping at MEM_DEPTH-1.
module spi_ram
  import slave_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam logic [ADDR_SIZE:0]   LP_DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LP_LAST  = ADDR_SIZE'(MEM_DEPTH-1);

  logic [ADDR_SIZE-1:0] r_mem [MEM_DEPTH];

  logic                 r_rx_valid_q;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wr_armed;
  logic                 r_rd_armed;
  logic [ADDR_SIZE-1:0] r_tx_data;
  logic                 r_tx_valid;
  logic                 r_cmd_err;

  ram_cmd_e             w_cmd;
  logic [ADDR_SIZE-1:0] w_payload;
  logic                 w_exec;
  logic                 w_in_range;
  logic                 w_wr_ok;

  assign w_cmd      = ram_cmd_e'(rx_data[ADDR_SIZE+1:ADDR_SIZE]);
  assign w_payload  = rx_data[ADDR_SIZE-1:0];
  // Reset takes priority: a rising edge coincident with reset is dropped.
  assign w_exec     = rst_n && rx_valid && !r_rx_valid_q;
  assign w_in_range = ({1'b0, w_payload} < LP_DEPTH);
  assign w_wr_ok    = w_exec && (w_cmd == WRITE_DATA) && r_wr_armed;

`ifdef SPI_RAM_AUTO_INC_EN
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LP_LAST) ? '0 : a + 1'b1;
  endfunction
`endif

  // Array kept out of the reset block so its contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_valid_q <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wr_armed   <= 1'b0;
      r_rd_armed   <= 1'b0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_rx_valid_q <= rx_valid;
      r_cmd_err    <= 1'b0;
      if (w_exec) begin
        // Only a successful READ_DATA re-asserts tx_valid below.
        r_tx_valid <= 1'b0;
        case (w_cmd)
          WRITE_ADD: begin
            if (w_in_range) begin
              r_wr_addr  <= w_payload;
              r_wr_armed <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          WRITE_DATA: begin
            if (r_wr_armed) begin
`ifdef SPI_RAM_AUTO_INC_EN
              r_wr_addr <= next_addr(r_wr_addr);
`endif
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          READ_ADD: begin
            if (w_in_range) begin
              r_rd_addr  <= w_payload;
              r_rd_armed <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
          READ_DATA: begin
            if (r_rd_armed) begin
              r_tx_data  <= r_mem[r_rd_addr];
              r_tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
              r_rd_addr  <= next_addr(r_rd_addr);
`endif
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: scoreboard bench for spi_ram. The driver updates a
// behavioural model for every command it issues and queues the expected
// response; a monitor watching the rx_valid edge at the DUT boundary pops
// and compares, and checks that outputs hold steady between commands.
// Follows SPI_RAM_AUTO_INC_EN the same way the design does.
module tb_spi_ram;

  localparam int DEPTH = 200;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW+1:0] rx_data;
  logic          rx_valid;
  logic [AW-1:0] tx_data;
  logic          tx_valid;
  logic          cmd_err;

  spi_ram #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       err;
    bit       tv;
    bit       tdk;   // tx_data value is known
    bit [7:0] td;
  } exp_t;

  exp_t q[$];

  bit [7:0] m_mem   [DEPTH];
  bit       m_known [DEPTH];
  int       m_wa, m_ra;
  bit       m_wa_arm, m_ra_arm, m_tv, m_tdk;
  bit [7:0] m_td;

  function automatic void m_reset();
    m_wa = 0; m_ra = 0; m_wa_arm = 0; m_ra_arm = 0;
    m_tv = 0; m_td = 0; m_tdk = 1;
  endfunction

  function automatic exp_t m_exec(input bit [1:0] c, input bit [7:0] p);
    exp_t e;
    bit   err = 0;
    case (c)
      2'd0: begin
        if (int'(p) < DEPTH) begin m_wa = int'(p); m_wa_arm = 1; end
        else err = 1;
        m_tv = 0;
      end
      2'd1: begin
        if (m_wa_arm) begin
          m_mem[m_wa] = p; m_known[m_wa] = 1;
`ifdef SPI_RAM_AUTO_INC_EN
          m_wa = (m_wa + 1) % DEPTH;
`endif
        end else err = 1;
        m_tv = 0;
      end
      2'd2: begin
        if (int'(p) < DEPTH) begin m_ra = int'(p); m_ra_arm = 1; end
        else err = 1;
        m_tv = 0;
      end
      default: begin
        if (m_ra_arm) begin
          m_td = m_mem[m_ra]; m_tdk = m_known[m_ra]; m_tv = 1;
`ifdef SPI_RAM_AUTO_INC_EN
          m_ra = (m_ra + 1) % DEPTH;
`endif
        end else begin
          err = 1; m_tv = 0;
        end
      end
    endcase
    e.err = err; e.tv = m_tv; e.tdk = m_tdk; e.td = m_td;
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit   checking = 0;
  bit   mon_rst  = 0;
  bit   mon_edge = 0;
  bit   prev_rv  = 0;
  exp_t last;

  always @(posedge clk) begin
    if (!rst_n) begin
      mon_rst  <= 1; mon_edge <= 0; prev_rv <= 0;
    end else begin
      mon_rst  <= 0;
      mon_edge <= rx_valid && !prev_rv;
      prev_rv  <= rx_valid;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      if (mon_rst) begin
        last.err = 0; last.tv = 0; last.tdk = 1; last.td = 0;
        chk("reset_cmd_err",  32'(cmd_err),  0);
        chk("reset_tx_valid", 32'(tx_valid), 0);
        chk("reset_tx_data",  32'(tx_data),  0);
      end else if (mon_edge) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_cmd: got a command response, expected none queued at %0t", $time);
        end else begin
          last = q.pop_front();
          chk("cmd_err",  32'(cmd_err),  32'(last.err));
          chk("tx_valid", 32'(tx_valid), 32'(last.tv));
          if (last.tdk) chk("tx_data", 32'(tx_data), 32'(last.td));
        end
      end else begin
        chk("idle_cmd_err",  32'(cmd_err),  0);
        chk("hold_tx_valid", 32'(tx_valid), 32'(last.tv));
        if (last.tdk) chk("hold_tx_data", 32'(tx_data), 32'(last.td));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input bit [1:0] c, input bit [7:0] p, input int hold = 1, input int gap = 1);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    q.push_back(m_exec(c, p));
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1;

    // Random activity while in reset; outputs must stay at zero.
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'($urandom);
      rx_data  = 10'($urandom);
      @(negedge clk);
    end
    // rx_valid rising together with reset release counts as a new edge.
    rx_data = {2'd0, 8'h00}; rx_valid = 1'b1; rst_n = 1'b1;
    m_reset();
    q.push_back(m_exec(2'd0, 8'h00));
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    send(2'd1, 8'h5A);

    // Data commands before any address command are rejected.
    do_reset(3);
    send(2'd1, 8'h77);
    send(2'd3, 8'h00);
    send(2'd2, 8'h00);
    send(2'd3, 8'h00);     // memory kept 0x5A through reset

    // Basic write then read back.
    send(2'd0, 8'h3C);
    send(2'd1, 8'hA5);
    send(2'd2, 8'h3C);
    send(2'd3, 8'h00, 1, 4);

    // Held rx_valid executes once.
    send(2'd0, 8'h11);
    send(2'd1, 8'h99);
    send(2'd0, 8'h10);
    send(2'd1, 8'h55, 5, 1);
    send(2'd2, 8'h10);
    send(2'd3, 8'h00);
    send(2'd2, 8'h11);
    send(2'd3, 8'h00);

    // Top of the array and wrap behaviour.
    send(2'd0, 8'(DEPTH-1));
    send(2'd1, 8'h11);
    send(2'd1, 8'h22);
    send(2'd2, 8'(DEPTH-1));
    send(2'd3, 8'h00);
    send(2'd3, 8'h00);

    // Out-of-range addresses are refused and leave the armed state alone.
    send(2'd0, 8'(DEPTH));
    send(2'd2, 8'hFF);
    send(2'd3, 8'h00);

    // Randomised traffic, biased toward in-range addresses.
    for (int i = 0; i < 200; i++) begin
      bit [1:0] c;
      bit [7:0] p;
      c = 2'($urandom);
      p = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(DEPTH, 255))
                                       : 8'($urandom_range(0, DEPTH-1));
      send(c, p, int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
    end

    // Reset while tx_valid is high clears it and disarms reads.
    send(2'd2, 8'h3C);
    send(2'd3, 8'h00, 1, 2);
    do_reset(1);
    send(2'd3, 8'h00, 1, 3);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
